// File: rtl/fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_scanout                                                   |
// | Description : VGA-style raster scanout of a 64x64 1bpp framebuffer, with   |
// |               SCALE x SCALE pixel replication and registered video outputs.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fb_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          SCALE    = 4,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [8:0]  vaddr,
  input  logic [31:0] vdata,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam int c_SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_HW-1:0] c_H_IMG    = c_HW'(64 * SCALE);
  localparam logic [c_HW-1:0] c_H_ONE    = c_HW'(1);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [c_VW-1:0] c_V_IMG    = c_VW'(64 * SCALE);
  localparam logic [c_VW-1:0] c_V_ONE    = c_VW'(1);
  localparam logic [c_SW-1:0] c_SUB_LAST = c_SW'(SCALE - 1);
  localparam logic [c_SW-1:0] c_SUB_ONE  = c_SW'(1);

  logic [c_HW-1:0] r_h_cnt;
  logic [c_VW-1:0] r_v_cnt;
  logic [c_SW-1:0] r_x_sub;
  logic [c_SW-1:0] r_y_sub;
  logic [5:0]      r_img_x;
  logic [5:0]      r_img_y;
  logic [31:0]     r_word;
  logic [8:0]      r_vaddr;
  logic            r_hsync_n;
  logic            r_vsync_n;
  logic            r_de;
  logic [11:0]     r_rgb;
  logic            r_frame_start;

  logic            w_in_img;
  logic            w_active;
  logic            w_load;
  logic            w_pix;
  logic            w_h_wrap;
  logic            w_v_wrap;
  logic            w_x_wrap;
  logic            w_y_wrap;
  logic [5:0]      w_next_row;

  assign w_in_img   = (r_h_cnt < c_H_IMG) && (r_v_cnt < c_V_IMG);
  assign w_active   = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_load     = w_in_img && (r_x_sub == '0) && (r_img_x[4:0] == 5'd0);
  // Bit 31 is the leftmost pixel; on a load strobe the fresh word bypasses r_word.
  assign w_pix      = w_load ? vdata[31] : r_word[~r_img_x[4:0]];
  assign w_h_wrap   = (r_h_cnt == c_H_LAST);
  assign w_v_wrap   = (r_v_cnt == c_V_LAST);
  assign w_x_wrap   = (r_x_sub == c_SUB_LAST);
  assign w_y_wrap   = (r_y_sub == c_SUB_LAST);
  // Row for the next raster line; 6-bit wrap takes row 63 back to row 0.
  assign w_next_row = w_y_wrap ? (r_img_y + 6'd1) : r_img_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x_sub       <= '0;
      r_y_sub       <= '0;
      r_img_x       <= '0;
      r_img_y       <= '0;
      r_word        <= '0;
      r_vaddr       <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_x_sub <= '0;
        r_img_x <= '0;
        if (w_v_wrap) begin
          r_v_cnt <= '0;
          r_y_sub <= '0;
          r_img_y <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + c_V_ONE;
          r_y_sub <= w_y_wrap ? '0 : (r_y_sub + c_SUB_ONE);
          r_img_y <= w_next_row;
        end
      end else begin
        r_h_cnt <= r_h_cnt + c_H_ONE;
        r_x_sub <= w_x_wrap ? '0 : (r_x_sub + c_SUB_ONE);
        if (w_x_wrap) begin
          r_img_x <= r_img_x + 6'd1;
        end
      end

      if (w_load) begin
        r_word  <= vdata;
        r_vaddr <= r_img_x[5] ? {w_next_row, 1'b0, 2'b00} : {r_img_y, 1'b1, 2'b00};
      end

      r_hsync_n     <= !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
      r_vsync_n     <= !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
      r_de          <= w_active;
      r_rgb         <= !w_active ? 12'h000 : ((w_in_img && w_pix) ? FG_COLOR : BG_COLOR);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end else begin
      // Single-clock pulse even when the strobe stalls.
      r_frame_start <= 1'b0;
    end
  end

  assign vaddr       = r_vaddr;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Video scanout engine on the data memory's dedicated video read port.
- Walks VGA-style raster counters and issues word-aligned byte addresses on vaddr. Consumes the returned 32-bit words as a 64x64 monochrome framebuffer (1 bpp, 2 words per row, 128 words = 512 bytes).
- Emits registered sync, data-enable and 12-bit colour towards the video DAC/pins.
- Each framebuffer pixel is replicated SCALE x SCALE on screen, anchored top-left.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SCALE, 4, pixel replication factor; 64*SCALE must be <= H_ACTIVE and <= V_ACTIVE
- FG_COLOR, 12'hFFF, colour for a framebuffer bit of 1
- BG_COLOR, 12'h008, colour for a framebuffer bit of 0 and for active area outside the image

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; all state advances only on clk edges where pix_en=1
- vaddr  out  9  byte address into the video port; bits [1:0] always 00
- vdata  in  32  word at vaddr, combinational (same-cycle) return
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  high during active video
- rgb  out  12  {R4,G4,B4}
- frame_start  out  1  one-clk pulse when the first active pixel of a frame is output

Behaviour:
- Reset (asynchronous, rst_n=0):
  - h_cnt=0, v_cnt=0, x_sub=0, y_sub=0, word_reg=0, vaddr=0.
  - hsync_n=1, vsync_n=1, de=0, rgb=0, frame_start=0.
  - Reset mid-frame restarts the raster at (0,0) on the first pix_en after release.
- Timing and counters:
  - H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
  - h_cnt wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
  - With pix_en=0 every register, including outputs, holds.
- Output latency: all outputs registered and mutually aligned, reflecting the counter values of the same pix_en edge (1 strobe latency).
  - hsync_n=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - de=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. When de=0, rgb=0.
- Image mapping:
  - Image region is h_cnt<64*SCALE and v_cnt<64*SCALE.
  - img_x = h_cnt/SCALE; img_y = v_cnt/SCALE, tracked incrementally via x_sub/y_sub, no dividers.
  - Word index = img_x[5]; pixel bit = word[31 - img_x[4:0]], so bit 31 is leftmost.
  - Active area outside the image -> BG_COLOR.
- Fetch:
  - vaddr = {img_y[5:0], word_idx, 2'b00}, registered. It must point at the next needed word at least one clk before that word's load strobe.
  - Load strobe: pix_en with in-image, x_sub=0, img_x[4:0]=0. On it, word_reg <= vdata and the output pixel uses vdata[31] directly.
  - After the word-0 load, vaddr -> word 1 of the same row.
  - After the word-1 load, vaddr -> word 0 of the next raster line's image row: same img_y if y_sub<SCALE-1, else img_y+1. After image row 63 with y_sub=SCALE-1, vaddr -> 0.
  - vaddr is otherwise stable; no fetch address change during blanking.
- frame_start:
  - Asserts for exactly one clk, coincident with the output registers of (h_cnt=0, v_cnt=0).
  - If pix_en stays high it deasserts on the next clk; it never stays high while pix_en is held low.

Test Plan:
- Reset then 800*525 pix_en strobes -> hsync_n low for 96 strobes per line starting 656 strobes after line start. vsync_n low on lines 490-491. de high for exactly 640*480 strobes. frame_start pulses once per 420000 strobes.
- RAM word 0 = 32'h8000_0001, word 1 = 0, rest 0 -> line 0: rgb=FG for pixels 0-3 and 124-127, BG for 4-123 and 128-639. Same pattern on lines 1-3, all BG on line 4.
- Word 127 = 32'hFFFF_FFFF -> lines 252-255: pixels 128-255 FG. Line 256: all BG. Trace shows vaddr returning to 0 after line 255's second load.
- Toggle pix_en 1-of-4 clks -> identical output sequence sampled on strobes; outputs and vaddr hold between strobes.
- Assert rst_n=0 mid-line 100 at h_cnt=300 -> outputs immediately at reset values without waiting for clk. After release, the first frame_start occurs on the first strobe.
- Sweep vaddr during frame: always word-aligned, always <= 9'h1FC, and stable for >=1 clk before each load strobe.
